// File: rtl/instr_cycle_ctrl_pkg.sv
// Shared constants for the machine-cycle controller: opcodes, FSM states, beat indices.
package instr_cycle_ctrl_pkg;

   localparam int unsigned BEAT_W = 2;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_EXEC   = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [BEAT_W-1:0] BEAT_T1 = 2'd0;
   localparam logic [BEAT_W-1:0] BEAT_T2 = 2'd1;
   localparam logic [BEAT_W-1:0] BEAT_T3 = 2'd2;

   // Control strobes driven toward datapath and memory
   typedef struct packed {
      logic mar_load;
      logic mem_rd;
      logic mem_wr;
      logic ir_load;
      logic pc_inc;
      logic pc_load;
      logic acc_load;
      logic alu_en;
      logic alu_sub;
   } strobe_t;

   // Beat that legally follows b in the T1->T2->T3->T1 rotation
   function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] b);
      return (b == BEAT_T3) ? BEAT_T1 : BEAT_W'(b + 2'd1);
   endfunction

endpackage

// File: rtl/instr_cycle_ctrl_beat_checker.sv
// Beat legality: one-hot, in-order, never while the generator is held; sticky error.
module instr_cycle_ctrl_beat_checker
   import instr_cycle_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        beats,
   input  logic              hold,
   input  logic              halted,
   output logic              beat_ok_c,
   output logic              beat_bad_c,
   output logic [BEAT_W-1:0] beat_idx_c,
   output logic              beat_err
);

   logic [BEAT_W-1:0] exp_q;
   logic [BEAT_W-1:0] exp_nx;
   logic              any_c;
   logic              multi_c;

   // Classify the sampled beat and advance/resync the expected beat
   always_comb begin
      any_c      = |beats;
      multi_c    = (beats & (beats - 3'd1)) != 3'd0;
      beat_idx_c = BEAT_T3;
      if (beats[0]) begin
         beat_idx_c = BEAT_T1;
      end else if (beats[1]) begin
         beat_idx_c = BEAT_T2;
      end
      beat_bad_c = any_c && !halted && (multi_c || hold || (beat_idx_c != exp_q));
      beat_ok_c  = any_c && !halted && !beat_bad_c;
      exp_nx     = exp_q;
      if (beat_bad_c) begin
         exp_nx = BEAT_T1;
      end else if (beat_ok_c) begin
         exp_nx = next_beat(exp_q);
      end
   end

   // Expected-beat tracker and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q    <= BEAT_T1;
         beat_err <= 1'b0;
      end else begin
         exp_q    <= exp_nx;
         beat_err <= beat_err | beat_bad_c;
      end
   end

endmodule

// File: rtl/instr_cycle_ctrl.sv
// FETCH/EXEC machine-cycle controller: per-beat strobes, memory wait states, halt.
module instr_cycle_ctrl
   import instr_cycle_ctrl_pkg::*;
#(
   parameter int unsigned OP_W     = 4,
   parameter int unsigned WAIT_MAX = 16
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic            T1,
   input  logic            T2,
   input  logic            T3,
   input  logic [OP_W-1:0] ir_op,
   input  logic            mem_ready,
   output logic            beat_hold,
   output logic            mar_load,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            ir_load,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            acc_load,
   output logic            alu_en,
   output logic            alu_sub,
   output logic            exec_phase,
   output logic            halt,
   output logic            illegal_op,
   output logic            beat_err,
   output logic            mem_timeout
);

   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

   logic [1:0]        state_q;
   logic [1:0]        state_nx;
   logic [OP_W-1:0]   op_q;
   logic [OP_W-1:0]   op_nx;
   strobe_t           stb_q;
   strobe_t           stb_nx;
   logic              hold_nx;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_nx;
   logic              tmo_nx;
   logic              ill_nx;
   logic              beat_ok_c;
   logic              beat_bad_c;
   logic [BEAT_W-1:0] beat_idx_c;

   instr_cycle_ctrl_beat_checker u_beat_chk (
      .clk        (sys_clk),
      .rst_n      (sys_rst),
      .beats      ({T3, T2, T1}),
      .hold       (beat_hold),
      .halted     (halt),
      .beat_ok_c  (beat_ok_c),
      .beat_bad_c (beat_bad_c),
      .beat_idx_c (beat_idx_c),
      .beat_err   (beat_err)
   );

   assign mar_load = stb_q.mar_load;
   assign mem_rd   = stb_q.mem_rd;
   assign mem_wr   = stb_q.mem_wr;
   assign ir_load  = stb_q.ir_load;
   assign pc_inc   = stb_q.pc_inc;
   assign pc_load  = stb_q.pc_load;
   assign acc_load = stb_q.acc_load;
   assign alu_en   = stb_q.alu_en;
   assign alu_sub  = stb_q.alu_sub;

   // Next state, next strobes and memory-wait bookkeeping
   always_comb begin
      state_nx      = state_q;
      op_nx         = op_q;
      stb_nx        = '0;
      stb_nx.mem_rd = stb_q.mem_rd;
      stb_nx.mem_wr = stb_q.mem_wr;
      hold_nx       = beat_hold;
      cnt_nx        = cnt_q;
      tmo_nx        = mem_timeout;
      ill_nx        = 1'b0;

      // An access in flight stays up until mem_ready is seen; a late memory only flags
      if (beat_hold) begin
         if (mem_ready) begin
            stb_nx.mem_rd = 1'b0;
            stb_nx.mem_wr = 1'b0;
            hold_nx       = 1'b0;
            cnt_nx        = '0;
         end else if (cnt_q != CNT_W'(WAIT_MAX)) begin
            cnt_nx = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
               tmo_nx = 1'b1;
            end
         end
      end

      if (beat_bad_c) begin
         state_nx = ST_FETCH;
      end else if (beat_ok_c) begin
         case (state_q)
            ST_FETCH: begin
               case (beat_idx_c)
                  BEAT_T1: stb_nx.mar_load = 1'b1;
                  BEAT_T2: begin
                     stb_nx.mem_rd = 1'b1;
                     hold_nx       = 1'b1;
                  end
                  default: begin
                     stb_nx.ir_load = 1'b1;
                     stb_nx.pc_inc  = 1'b1;
                     state_nx       = ST_EXEC;
                  end
               endcase
            end
            ST_EXEC: begin
               case (beat_idx_c)
                  BEAT_T1: begin
                     op_nx = ir_op;
                     case (ir_op)
                        OP_W'(OP_NOP): ill_nx = 1'b0;
                        OP_W'(OP_LDA), OP_W'(OP_ADD),
                        OP_W'(OP_SUB), OP_W'(OP_STA): stb_nx.mar_load = 1'b1;
                        OP_W'(OP_JMP): stb_nx.pc_load = 1'b1;
                        OP_W'(OP_HLT): state_nx = ST_HALTED;
                        default: ill_nx = 1'b1;
                     endcase
                  end
                  BEAT_T2: begin
                     case (op_q)
                        OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                           stb_nx.mem_rd = 1'b1;
                           hold_nx       = 1'b1;
                        end
                        OP_W'(OP_STA): begin
                           stb_nx.mem_wr = 1'b1;
                           hold_nx       = 1'b1;
                        end
                        default: hold_nx = beat_hold;
                     endcase
                  end
                  default: begin
                     case (op_q)
                        OP_W'(OP_LDA): stb_nx.acc_load = 1'b1;
                        OP_W'(OP_ADD): begin
                           stb_nx.acc_load = 1'b1;
                           stb_nx.alu_en   = 1'b1;
                        end
                        OP_W'(OP_SUB): begin
                           stb_nx.acc_load = 1'b1;
                           stb_nx.alu_en   = 1'b1;
                           stb_nx.alu_sub  = 1'b1;
                        end
                        default: stb_nx.acc_load = 1'b0;
                     endcase
                     state_nx = ST_FETCH;
                  end
               endcase
            end
            default: state_nx = state_q;
         endcase
      end
   end

   // State and registered outputs; HALTED reports exec_phase=0
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= ST_FETCH;
         op_q        <= '0;
         stb_q       <= '0;
         beat_hold   <= 1'b0;
         cnt_q       <= '0;
         mem_timeout <= 1'b0;
         illegal_op  <= 1'b0;
         halt        <= 1'b0;
         exec_phase  <= 1'b0;
      end else begin
         state_q     <= state_nx;
         op_q        <= op_nx;
         stb_q       <= stb_nx;
         beat_hold   <= hold_nx;
         cnt_q       <= cnt_nx;
         mem_timeout <= tmo_nx;
         illegal_op  <= ill_nx;
         halt        <= (state_nx == ST_HALTED);
         exec_phase  <= (state_nx == ST_EXEC);
      end
   end

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Self-checking bench for instr_cycle_ctrl against a beat-level reference model.
module tb_instr_cycle_ctrl;
   import instr_cycle_ctrl_pkg::*;

   localparam int WAIT_MAX = 16;

   typedef struct packed {
      logic hold, mar, rd, wr, ir, pci, pcl, acc, alu, sub, exph, hlt, ill, berr, tmo;
   } outs_t;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       T1, T2, T3;
   logic [3:0] ir_op;
   logic       mem_ready;
   logic beat_hold, mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load;
   logic alu_en, alu_sub, exec_phase, halt, illegal_op, beat_err, mem_timeout;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   bit         m_exec, m_halted, m_err, m_tmo;
   int         m_next;
   logic [3:0] m_op;

   instr_cycle_ctrl #(.OP_W(4), .WAIT_MAX(WAIT_MAX)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .T1(T1), .T2(T2), .T3(T3),
      .ir_op(ir_op), .mem_ready(mem_ready), .beat_hold(beat_hold),
      .mar_load(mar_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load),
      .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load), .alu_en(alu_en),
      .alu_sub(alu_sub), .exec_phase(exec_phase), .halt(halt),
      .illegal_op(illegal_op), .beat_err(beat_err), .mem_timeout(mem_timeout)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic outs_t sample();
      outs_t o;
      o = {beat_hold, mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load,
           alu_en, alu_sub, exec_phase, halt, illegal_op, beat_err, mem_timeout};
      return o;
   endfunction

   function automatic outs_t base();
      outs_t o;
      o = '0;
      o.exph = m_exec;
      o.hlt  = m_halted;
      o.berr = m_err;
      o.tmo  = m_tmo;
      return o;
   endfunction

   task automatic check_eq(input string tag, input outs_t got, input outs_t want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%b want=%b (hold mar rd wr ir pci pcl acc alu sub exph hlt ill berr tmo)",
                  tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_reset();
      m_exec = 0; m_halted = 0; m_err = 0; m_tmo = 0; m_next = 1; m_op = '0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_eq("idle", sample(), base());
      end
   endtask

   // Drive one beat vector (bit0=T1); wait_n = cycles mem_ready stays low if it starts an access
   task automatic beat(input logic [2:0] v, input int wait_n);
      outs_t s, e;
      bit    mem;
      int    b;
      s = '0;
      mem = 0;
      {T3, T2, T1} = v;
      mem_ready = 1'b0;
      if (!m_halted) begin
         b = v[0] ? 1 : (v[1] ? 2 : 3);
         if ($countones(v) != 1 || b != m_next) begin
            m_err = 1; m_exec = 0; m_next = 1;
         end else begin
            if (!m_exec) begin
               case (b)
                  1: s.mar = 1;
                  2: begin s.rd = 1; mem = 1; end
                  default: begin s.ir = 1; s.pci = 1; m_exec = 1; end
               endcase
            end else begin
               case (b)
                  1: begin
                     m_op = ir_op;
                     if (m_op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA}) s.mar = 1;
                     else if (m_op == OP_JMP) s.pcl = 1;
                     else if (m_op == OP_HLT) begin m_halted = 1; m_exec = 0; end
                     else if (m_op != OP_NOP) s.ill = 1;
                  end
                  2: begin
                     if (m_op inside {OP_LDA, OP_ADD, OP_SUB}) begin s.rd = 1; mem = 1; end
                     else if (m_op == OP_STA) begin s.wr = 1; mem = 1; end
                  end
                  default: begin
                     s.acc  = m_op inside {OP_LDA, OP_ADD, OP_SUB};
                     s.alu  = m_op inside {OP_ADD, OP_SUB};
                     s.sub  = (m_op == OP_SUB);
                     m_exec = 0;
                  end
               endcase
            end
            m_next = (b % 3) + 1;
         end
      end
      s.hold = mem;
      e = outs_t'(base() | s);
      tick();
      {T3, T2, T1} = 3'b000;
      if (mem) begin
         for (int j = 1; j <= wait_n + 1; j++) begin
            mem_ready = (j == wait_n + 1);
            e.tmo = m_tmo | ((j - 1) >= WAIT_MAX);
            check_eq("mem_access", sample(), e);
            tick();
         end
         mem_ready = 1'b0;
         if (wait_n >= WAIT_MAX) m_tmo = 1;
      end else begin
         check_eq("strobe", sample(), e);
         tick();
      end
      check_eq("after_beat", sample(), base());
   endtask

   task automatic bt(input int b, input int w);
      beat(3'(1 << (b - 1)), w);
   endtask

   task automatic run_instr(input logic [3:0] op, input int wf, input int we);
      bt(1, 0); bt(2, wf); bt(3, 0);
      ir_op = op;
      bt(1, 0); bt(2, we); bt(3, 0);
   endtask

   initial begin
      outs_t e;
      logic [3:0] op;
      {T3, T2, T1} = 3'b000;
      ir_op = '0;
      mem_ready = 1'b0;
      model_reset();

      // Reset low for 10 time units
      sys_rst = 1'b1;
      #1 sys_rst = 1'b0;
      #2 check_eq("in_reset", sample(), outs_t'(0));
      #8 sys_rst = 1'b1;
      idle_cycles(3);

      // Directed instructions
      run_instr(OP_LDA, 0, 0);
      run_instr(OP_SUB, 1, 3);
      run_instr(4'h9, 0, 0);
      run_instr(OP_JMP, 2, 0);
      run_instr(OP_ADD, 0, 2);

      // Random program of non-halting instructions
      for (int k = 0; k < 40; k++) begin
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 14)) : 4'($urandom_range(0, 5));
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
         idle_cycles($urandom_range(0, 2));
      end

      // Store with a late memory: timeout after WAIT_MAX cycles, write held to mem_ready
      run_instr(OP_STA, 0, 20);
      idle_cycles(2);

      // T2 skipped in FETCH, then a normal fetch restart
      bt(1, 0); bt(3, 0);
      run_instr(OP_LDA, 0, 1);

      // Out-of-order beat inside EXEC
      bt(1, 0); bt(2, 0); bt(3, 0);
      ir_op = OP_JMP;
      bt(1, 0); bt(1, 0);
      run_instr(OP_NOP, 0, 0);

      // Two beats at once
      beat(3'b011, 0);
      run_instr(OP_SUB, 0, 0);

      // Beat arriving while the generator is held
      bt(1, 0);
      {T3, T2, T1} = 3'b010; mem_ready = 1'b0;
      tick();
      {T3, T2, T1} = 3'b000;
      m_next = 3;
      e = base(); e.rd = 1; e.hold = 1;
      check_eq("hold_rd", sample(), e);
      T3 = 1'b1;
      tick();
      T3 = 1'b0;
      m_err = 1; m_exec = 0; m_next = 1;
      e.berr = 1;
      check_eq("beat_in_hold", sample(), e);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check_eq("hold_release", sample(), base());
      run_instr(OP_LDA, 0, 0);

      // Asynchronous reset in the middle of a read
      bt(1, 0);
      {T3, T2, T1} = 3'b010; mem_ready = 1'b0;
      tick();
      {T3, T2, T1} = 3'b000;
      e = base(); e.rd = 1; e.hold = 1;
      check_eq("pre_reset_rd", sample(), e);
      #2 sys_rst = 1'b0;
      #1 check_eq("async_reset", sample(), outs_t'(0));
      model_reset();
      tick(); tick();
      sys_rst = 1'b1;
      idle_cycles(2);
      run_instr(OP_ADD, 1, 1);

      // Halt, then beats (legal or not) are ignored
      run_instr(OP_HLT, 0, 0);
      bt(1, 0); bt(2, 3); bt(3, 0);
      beat(3'b111, 0);
      idle_cycles(3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
